// File: rtl/l2req_credit_scheduler_pkg.sv
// Shared unit indices and width helpers for the L2 request credit scheduler.
package l2req_credit_scheduler_pkg;

    localparam int L2_UNIT_ICACHE = 0;
    localparam int L2_UNIT_DCACHE = 1;
    localparam int L2_UNIT_STBUF  = 2;
    localparam int L2_NUM_UNITS   = L2_UNIT_STBUF + 1;

    // A single requester still needs a one-bit unit id on the L2 side.
    function automatic int unit_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l2req_rr_picker.sv
// Round-robin picker: first asserted request at or after the pointer, wrapping, as a one-hot grant.
module l2req_rr_picker #(
    parameter int NUM_REQUESTERS = 3,
    parameter int PTR_WIDTH      = 2
) (
    input  logic [NUM_REQUESTERS-1:0] req_i,
    input  logic [PTR_WIDTH-1:0]      ptr_i,
    output logic [NUM_REQUESTERS-1:0] grant_o
);

    logic found;
    int   idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= NUM_REQUESTERS) begin
                idx = idx - NUM_REQUESTERS;
            end
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/l2req_credit_scheduler.sv
// Shares the L2 request port between L1-side units, capping each unit's in-flight
// requests with a credit counter and granting eligible units round-robin.
module l2req_credit_scheduler
    import l2req_credit_scheduler_pkg::*;
#(
    parameter int  NUM_REQUESTERS  = L2_NUM_UNITS,
    parameter int  PACKET_WIDTH    = 96,
    parameter int  MAX_OUTSTANDING = 4,
    localparam int UNIT_WIDTH      = unit_width(NUM_REQUESTERS),
    localparam int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_REQUESTERS-1:0]              req_valid,
    input  logic [NUM_REQUESTERS*PACKET_WIDTH-1:0] req_packet,
    output logic [NUM_REQUESTERS-1:0]              req_ready,
    output logic                                   l2req_valid,
    output logic [PACKET_WIDTH-1:0]                l2req_packet,
    output logic [UNIT_WIDTH-1:0]                  l2req_unit,
    input  logic                                   l2req_ready,
    input  logic                                   l2rsp_valid,
    input  logic [UNIT_WIDTH-1:0]                  l2rsp_unit,
    output logic [NUM_REQUESTERS*CNT_WIDTH-1:0]    outstanding,
    output logic                                   idle,
    output logic                                   credit_error
);

    localparam logic [CNT_WIDTH-1:0]  MAX_CNT  = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [UNIT_WIDTH-1:0] UNIT_ONE = UNIT_WIDTH'(1);

    logic [CNT_WIDTH-1:0]      cnt_q [NUM_REQUESTERS];
    logic [CNT_WIDTH-1:0]      cnt_d [NUM_REQUESTERS];
    logic                      valid_q, valid_d;
    logic [PACKET_WIDTH-1:0]   packet_q, packet_d;
    logic [UNIT_WIDTH-1:0]     unit_q, unit_d;
    logic [UNIT_WIDTH-1:0]     ptr_q, ptr_d;
    logic                      err_q, err_d;

    logic                      load;
    logic [NUM_REQUESTERS-1:0] eligible;
    logic [NUM_REQUESTERS-1:0] grant;
    logic [NUM_REQUESTERS-1:0] rsp_hit;
    logic [UNIT_WIDTH-1:0]     grant_idx;
    logic [PACKET_WIDTH-1:0]   grant_packet;
    logic                      rsp_in_range;
    logic                      any_busy;

    // Handshake: the output stage reloads when empty or when L2 takes it this cycle,
    // so back-to-back grants run without a bubble. A unit's request is taken exactly
    // when req_ready[i] is high at the clock edge; l2req_* transfers on valid && ready.
    assign load = !valid_q || l2req_ready;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            eligible[i] = req_valid[i] && (cnt_q[i] < MAX_CNT) && load;
        end
    end

    l2req_rr_picker #(
        .NUM_REQUESTERS (NUM_REQUESTERS),
        .PTR_WIDTH      (UNIT_WIDTH)
    ) u_picker (
        .req_i   (eligible),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    assign req_ready = grant;

    always_comb begin
        grant_idx    = '0;
        grant_packet = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (grant[i]) begin
                grant_idx    = UNIT_WIDTH'(i);
                grant_packet = req_packet[i*PACKET_WIDTH +: PACKET_WIDTH];
            end
        end
    end

    assign rsp_in_range = int'(l2rsp_unit) < NUM_REQUESTERS;

    // Credit is charged at grant; a same-cycle grant and response on one unit cancel.
    always_comb begin
        err_d   = err_q;
        rsp_hit = '0;
        if (l2rsp_valid && !rsp_in_range) begin
            err_d = 1'b1;
        end
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            cnt_d[i]   = cnt_q[i];
            rsp_hit[i] = l2rsp_valid && rsp_in_range && (l2rsp_unit == UNIT_WIDTH'(i));
            if (grant[i] && !rsp_hit[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (rsp_hit[i] && !grant[i]) begin
                if (cnt_q[i] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        valid_d  = valid_q;
        packet_d = packet_q;
        unit_d   = unit_q;
        ptr_d    = ptr_q;
        if (load) begin
            valid_d = |grant;
            if (|grant) begin
                packet_d = grant_packet;
                unit_d   = grant_idx;
                ptr_d    = (int'(grant_idx) == NUM_REQUESTERS - 1) ? '0 : grant_idx + UNIT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            packet_q <= '0;
            unit_q   <= '0;
            ptr_q    <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < NUM_REQUESTERS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            packet_q <= packet_d;
            unit_q   <= unit_d;
            ptr_q    <= ptr_d;
            err_q    <= err_d;
            for (int i = 0; i < NUM_REQUESTERS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        outstanding = '0;
        any_busy    = 1'b0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            outstanding[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
            any_busy = any_busy || (cnt_q[i] != '0);
        end
    end

    assign l2req_valid  = valid_q;
    assign l2req_packet = packet_q;
    assign l2req_unit   = unit_q;
    assign credit_error = err_q;
    assign idle         = !any_busy && !valid_q;

endmodule

// File: tb/tb_l2req_credit_scheduler.sv
// Table-driven bench for the L2 request credit scheduler with a packet scoreboard.
module tb_l2req_credit_scheduler;

    localparam int N  = 3;
    localparam int PW = 96;
    localparam int UW = 2;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*PW-1:0]   req_packet;
    logic [N-1:0]      req_ready;
    logic              l2req_valid;
    logic [PW-1:0]     l2req_packet;
    logic [UW-1:0]     l2req_unit;
    logic              l2req_ready;
    logic              l2rsp_valid;
    logic [UW-1:0]     l2rsp_unit;
    logic [N*CW-1:0]   outstanding;
    logic              idle;
    logic              credit_error;

    l2req_credit_scheduler #(
        .NUM_REQUESTERS  (N),
        .PACKET_WIDTH    (PW),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_packet   (req_packet),
        .req_ready    (req_ready),
        .l2req_valid  (l2req_valid),
        .l2req_packet (l2req_packet),
        .l2req_unit   (l2req_unit),
        .l2req_ready  (l2req_ready),
        .l2rsp_valid  (l2rsp_valid),
        .l2rsp_unit   (l2rsp_unit),
        .outstanding  (outstanding),
        .idle         (idle),
        .credit_error (credit_error)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] rv;
        logic       rdy;
        logic       rspv;
        logic [1:0] rspu;
        logic [2:0] e_ready;
        logic       e_valid;
        logic [1:0] e_unit;
        int         c0;
        int         c1;
        int         c2;
        logic       e_err;
    } vec_t;

    vec_t              vecs[$];
    logic [PW+UW-1:0]  exp_q[$];
    logic [PW-1:0]     pkt[N];
    int                checks = 0;
    int                errors = 0;

    function automatic vec_t mk(input logic [2:0] rv, input logic rdy, input logic rspv,
                                input logic [1:0] rspu, input logic [2:0] e_ready,
                                input logic e_valid, input logic [1:0] e_unit,
                                input int c0, input int c1, input int c2, input logic e_err);
        vec_t v;
        v.rv = rv; v.rdy = rdy; v.rspv = rspv; v.rspu = rspu;
        v.e_ready = e_ready; v.e_valid = e_valid; v.e_unit = e_unit;
        v.c0 = c0; v.c1 = c1; v.c2 = c2; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver: called just after a rising edge; checks comb outputs mid-cycle, registered ones after the edge
    task automatic apply(input vec_t v, input int idx);
        logic [PW+UW-1:0] front;
        logic [N*CW-1:0]  exp_out;
        req_valid   = v.rv;
        l2req_ready = v.rdy;
        l2rsp_valid = v.rspv;
        l2rsp_unit  = v.rspu;
        for (int u = 0; u < N; u++) begin
            pkt[u] = {$urandom, $urandom, $urandom};
            req_packet[u*PW +: PW] = pkt[u];
        end
        #3;
        check($sformatf("req_ready[%0d]", idx), 128'(req_ready), 128'(v.e_ready));
        if (l2req_valid && l2req_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL accept[%0d]: got unexpected request from unit %0d, expected none", idx, l2req_unit);
            end else begin
                front = exp_q.pop_front();
                check($sformatf("accept[%0d]", idx), 128'({l2req_unit, l2req_packet}), 128'(front));
            end
        end
        for (int u = 0; u < N; u++) begin
            if (v.e_ready[u]) exp_q.push_back({UW'(u), pkt[u]});
        end
        @(posedge clk);
        #1;
        exp_out = {CW'(v.c2), CW'(v.c1), CW'(v.c0)};
        check($sformatf("l2req_valid[%0d]", idx), 128'(l2req_valid), 128'(v.e_valid));
        if (v.e_valid) check($sformatf("l2req_unit[%0d]", idx), 128'(l2req_unit), 128'(v.e_unit));
        check($sformatf("outstanding[%0d]", idx), 128'(outstanding), 128'(exp_out));
        check($sformatf("credit_error[%0d]", idx), 128'(credit_error), 128'(v.e_err));
        check($sformatf("idle[%0d]", idx), 128'(idle),
              128'(!v.e_valid && v.c0 == 0 && v.c1 == 0 && v.c2 == 0));
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = '0;
        req_packet  = '0;
        l2req_ready = 1'b0;
        l2rsp_valid = 1'b0;
        l2rsp_unit  = '0;

        // round robin 0,1,2 then drain
        vecs.push_back(mk(3'b111, 1, 0, 0, 3'b001, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(3'b111, 1, 0, 0, 3'b010, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(3'b111, 1, 0, 0, 3'b100, 1, 2, 1, 1, 1, 0));
        vecs.push_back(mk(3'b000, 1, 1, 0, 3'b000, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(3'b000, 1, 1, 1, 3'b000, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(3'b000, 1, 1, 2, 3'b000, 0, 0, 0, 0, 0, 0));
        // unit 1 alone up to the credit cap, freed by one response
        vecs.push_back(mk(3'b010, 1, 0, 0, 3'b010, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(3'b010, 1, 0, 0, 3'b010, 1, 1, 0, 2, 0, 0));
        vecs.push_back(mk(3'b010, 1, 0, 0, 3'b010, 1, 1, 0, 3, 0, 0));
        vecs.push_back(mk(3'b010, 1, 0, 0, 3'b010, 1, 1, 0, 4, 0, 0));
        vecs.push_back(mk(3'b010, 1, 0, 0, 3'b000, 0, 0, 0, 4, 0, 0));
        vecs.push_back(mk(3'b010, 1, 1, 1, 3'b000, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(3'b010, 1, 0, 0, 3'b010, 1, 1, 0, 4, 0, 0));
        vecs.push_back(mk(3'b000, 1, 1, 1, 3'b000, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(3'b000, 1, 1, 1, 3'b000, 0, 0, 0, 2, 0, 0));
        vecs.push_back(mk(3'b000, 1, 1, 1, 3'b000, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(3'b000, 1, 1, 1, 3'b000, 0, 0, 0, 0, 0, 0));
        // L2 stall for 5 cycles; pointer is at 2
        vecs.push_back(mk(3'b111, 1, 0, 0, 3'b100, 1, 2, 0, 0, 1, 0));
        for (int s = 0; s < 5; s++) vecs.push_back(mk(3'b111, 0, 0, 0, 3'b000, 1, 2, 0, 0, 1, 0));
        vecs.push_back(mk(3'b111, 1, 0, 0, 3'b001, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(3'b000, 1, 0, 0, 3'b000, 0, 0, 1, 0, 1, 0));
        // same-cycle grant and response on unit 2 with count 2
        vecs.push_back(mk(3'b100, 1, 0, 0, 3'b100, 1, 2, 1, 0, 2, 0));
        vecs.push_back(mk(3'b100, 1, 1, 2, 3'b100, 1, 2, 1, 0, 2, 0));
        vecs.push_back(mk(3'b000, 1, 1, 0, 3'b000, 0, 0, 0, 0, 2, 0));
        // credit errors: underflow, out-of-range unit, stickiness
        vecs.push_back(mk(3'b000, 1, 1, 0, 3'b000, 0, 0, 0, 0, 2, 1));
        vecs.push_back(mk(3'b000, 1, 1, 3, 3'b000, 0, 0, 0, 0, 2, 1));
        vecs.push_back(mk(3'b000, 1, 0, 0, 3'b000, 0, 0, 0, 0, 2, 1));

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_idle", 128'(idle), 128'(1));
        check("reset_l2req_valid", 128'(l2req_valid), 128'(0));
        check("reset_outstanding", 128'(outstanding), 128'(0));
        check("reset_credit_error", 128'(credit_error), 128'(0));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        // asynchronous reset in the middle of traffic, away from any clock edge
        req_valid   = 3'b111;
        l2req_ready = 1'b0;
        l2rsp_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset_valid", 128'(l2req_valid), 128'(1));
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        check("async_reset_valid", 128'(l2req_valid), 128'(0));
        check("async_reset_packet", 128'(l2req_packet), 128'(0));
        check("async_reset_unit", 128'(l2req_unit), 128'(0));
        check("async_reset_outstanding", 128'(outstanding), 128'(0));
        check("async_reset_error", 128'(credit_error), 128'(0));
        check("async_reset_idle", 128'(idle), 128'(1));
        req_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
